// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, immediate-select enum and decoded-entry struct for decode_stage
package decode_pkg;

  localparam int DEC_XLEN = 32;
  localparam int DEC_IMMW = 25;

  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_U    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_src_t;

  typedef struct packed {
    logic [DEC_XLEN-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [DEC_IMMW-1:0] imm;
    imm_src_t            imm_src;
    logic                illegal;
  } dec_t;

  localparam dec_t DEC_ZERO = '0;

  // Unknown opcodes select IMM_NONE so the extender produces zero.
  function automatic imm_src_t imm_src_of(input logic [6:0] opc);
    imm_src_t src;
    case (opc)
      OPC_IALU:   src = IMM_I;
      OPC_LUI:    src = IMM_U;
      OPC_STORE:  src = IMM_S;
      OPC_BRANCH: src = IMM_B;
      OPC_JAL:    src = IMM_J;
      default:    src = IMM_NONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational split of one instruction into a decoded entry
module decode_fields
  import decode_pkg::*;
(
  input  logic [DEC_XLEN-1:0] i_instr,
  input  logic [DEC_XLEN-1:0] i_pc,
  output dec_t                o_dec
);

  imm_src_t w_src;

  assign w_src = imm_src_of(i_instr[6:0]);

  assign o_dec.pc      = i_pc;
  assign o_dec.opcode  = i_instr[6:0];
  assign o_dec.rd      = i_instr[11:7];
  assign o_dec.rs1     = i_instr[19:15];
  assign o_dec.rs2     = i_instr[24:20];
  assign o_dec.imm     = i_instr[31:7];
  assign o_dec.imm_src = w_src;
  // An all-zero word is never a real instruction; it usually means fetch read unprogrammed memory.
  assign o_dec.illegal = (w_src == IMM_NONE) || (i_instr == '0);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID stage with 2-entry skid buffer; optional out_illegal via DECODE_ILLEGAL_TRAP_EN
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = DEC_XLEN,
  parameter int IMMW = DEC_IMMW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [IMMW-1:0] out_imm,
  output logic [2:0]      out_imm_src
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic            out_illegal
`endif
);

  dec_t r_head;
  dec_t r_skid;
  logic r_head_valid;
  logic r_skid_valid;
  logic r_in_ready;

  dec_t w_dec;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_head_free;

  // Decode happens once, on the way into the buffer, so outputs are pure flops.
  decode_fields u_decode_fields (
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .o_dec   (w_dec)
  );

  assign w_in_xfer   = in_valid && r_in_ready;
  assign w_out_xfer  = r_head_valid && out_ready;
  assign w_head_free = !r_head_valid || w_out_xfer;

  // Skid buffer: head feeds execute, skid absorbs the one instruction that slips in while in_ready is still high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head       <= DEC_ZERO;
      r_skid       <= DEC_ZERO;
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_head       <= DEC_ZERO;
      r_skid       <= DEC_ZERO;
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (r_skid_valid) begin
      // in_ready is low here, so only a drain can change state.
      if (w_out_xfer) begin
        r_head       <= r_skid;
        r_skid       <= DEC_ZERO;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_in_xfer) begin
      if (w_head_free) begin
        r_head       <= w_dec;
        r_head_valid <= 1'b1;
      end else begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end else if (w_out_xfer) begin
      r_head       <= DEC_ZERO;
      r_head_valid <= 1'b0;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_head_valid;
  assign out_pc      = r_head.pc;
  assign out_opcode  = r_head.opcode;
  assign out_rd      = r_head.rd;
  assign out_rs1     = r_head.rs1;
  assign out_rs2     = r_head.rs2;
  assign out_imm     = r_head.imm;
  assign out_imm_src = r_head.imm_src;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal = r_head.illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = r_head.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed self-checking bench for decode_stage against a queue model
module tb_decode_stage;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [24:0] out_imm;
  logic [2:0]  out_imm_src;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the stage is a 2-deep FIFO of {pc, instr}; accepted while fewer than 2 are held.
  logic [63:0] q[$];

  decode_stage dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .out_imm_src (out_imm_src)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_src(input logic [6:0] op);
    case (op)
      7'b0010011: return 3'b000;
      7'b0110111: return 3'b001;
      7'b0100011: return 3'b010;
      7'b1100011: return 3'b011;
      7'b1101111: return 3'b100;
      default:    return 3'b111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " data"}, {16'd0, out_pc[15:0] | out_pc[31:16]} | {25'd0, out_opcode} | {27'd0, out_rd}
        | {27'd0, out_rs1} | {27'd0, out_rs2} | {7'd0, out_imm} | {29'd0, out_imm_src}, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk({tag, " illegal"}, {31'd0, out_illegal}, 32'd0);
`endif
  endtask

  task automatic check_model();
    logic [31:0] ei;
    logic [31:0] ep;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      ep = q[0][63:32];
      ei = q[0][31:0];
      chk("out_pc", out_pc, ep);
      chk("out_opcode", {25'd0, out_opcode}, {25'd0, ei[6:0]});
      chk("out_rd", {27'd0, out_rd}, {27'd0, ei[11:7]});
      chk("out_rs1", {27'd0, out_rs1}, {27'd0, ei[19:15]});
      chk("out_rs2", {27'd0, out_rs2}, {27'd0, ei[24:20]});
      chk("out_imm", {7'd0, out_imm}, ei >> 7);
      chk("out_imm_src", {29'd0, out_imm_src}, {29'd0, exp_src(ei[6:0])});
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("out_illegal", {31'd0, out_illegal},
          {31'd0, (exp_src(ei[6:0]) == 3'b111) || (ei == 32'd0)});
`endif
    end
  endtask

  // Drive on the falling edge, then compare against the model before the rising edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_model();
  endtask

  task automatic tick();
    bit acc;
    bit drn;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back({in_pc, in_instr});
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    drive(v, ins, pc, ordy, fl);
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 8))
      0: op = 7'b0010011;
      1: op = 7'b0110111;
      2: op = 7'b0100011;
      3: op = 7'b1100011;
      4: op = 7'b1101111;
      5: op = 7'h7F;
      6: op = 7'h33;
      7: op = 7'h03;
      default: return 32'd0;
    endcase
    return {r[31:7], op};
  endfunction

  initial begin
    logic [31:0] pc;
    logic [6:0]  ops[4];
    ops[0] = 7'b0110111;
    ops[1] = 7'b0100011;
    ops[2] = 7'b1100011;
    ops[3] = 7'b1101111;

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Single I-ALU instruction.
    step(1'b1, 32'h00A00093, 32'h100, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("alu valid", {31'd0, out_valid}, 32'd1);
    chk("alu opcode", {25'd0, out_opcode}, 32'h13);
    chk("alu rd", {27'd0, out_rd}, 32'd1);
    chk("alu rs1", {27'd0, out_rs1}, 32'd0);
    chk("alu imm", {7'd0, out_imm}, 32'h0014001);
    chk("alu imm_src", {29'd0, out_imm_src}, 32'd0);
    chk("alu pc", out_pc, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("alu gone", {31'd0, out_valid}, 32'd0);
    tick();

    // Streaming LUI/store/branch/JAL with execute always ready.
    pc = 32'h200;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] r;
      r = $urandom;
      drive(1'b1, {r[31:7], ops[i % 4]}, pc, 1'b1, 1'b0);
      chk("stream in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) chk("stream imm_src", {29'd0, out_imm_src}, {29'd0, exp_src(ops[(i - 1) % 4])});
      tick();
      pc += 4;
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall: three offered, two accepted, then drain A then B.
    step(1'b1, 32'h00100013, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00200013, 32'h304, 1'b0, 1'b0);
    drive(1'b1, 32'h00300013, 32'h308, 1'b0, 1'b0);
    chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall head A", out_pc, 32'h300);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain A", out_pc, 32'h300);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain B", out_pc, 32'h304);
    chk("ready back", {31'd0, in_ready}, 32'd1);
    tick();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with both entries full and an instruction offered.
    step(1'b1, 32'h00100037, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00200037, 32'h404, 1'b0, 1'b0);
    step(1'b1, 32'h00300037, 32'h408, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk_zero_outputs("flush");
    tick();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush racing an accept into an empty stage drops the incoming word.
    step(1'b1, 32'h0000006F, 32'h480, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk_zero_outputs("flush race");
    tick();

    // Asynchronous reset in the middle of a stall.
    step(1'b1, 32'h00100023, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h00200023, 32'h504, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_zero_outputs("async reset");
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

`ifdef DECODE_ILLEGAL_TRAP_EN
    step(1'b1, 32'h0000007F, 32'h600, 1'b1, 1'b0);
    drive(1'b1, 32'h00000000, 32'h604, 1'b1, 1'b0);
    chk("illegal 7f", {31'd0, out_illegal}, 32'd1);
    chk("illegal 7f src", {29'd0, out_imm_src}, 32'd7);
    tick();
    drive(1'b1, 32'h00A00093, 32'h608, 1'b1, 1'b0);
    chk("illegal zero", {31'd0, out_illegal}, 32'd1);
    chk("illegal zero src", {29'd0, out_imm_src}, 32'd7);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("legal", {31'd0, out_illegal}, 32'd0);
    tick();
`endif

    // Random traffic.
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), pc, $urandom_range(0, 9) < 6,
           $urandom_range(0, 39) == 0);
      pc += 4;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
